// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: opcode constants, queue entry layout, B-immediate helper.
package fetch_stage_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } fetch_entry_t;

    function automatic logic is_branch(input logic [31:0] instr);
        return instr[6:0] == OPC_BRANCH;
    endfunction

    // Sign-extended B-type immediate, also used by decode.
    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for the instruction queue and the request tag queue.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // NOTE: storage is not reset; r_count gates validity and consumers mask the head when empty.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, queues in-order responses for decode.
// Optional static backward-taken prediction is compiled in with `define STATIC_PREDICT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        pred_taken
);

    localparam int             CNT_W     = $clog2(FIFO_DEPTH+1);
    localparam int             ENTRY_W   = $bits(fetch_entry_t);
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);

    logic             r_run;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [CNT_W-1:0] w_live_cnt;
    logic [CNT_W-1:0] w_iq_count;
    logic             w_tag_full;
    logic             w_tag_empty;
    logic             w_iq_full;
    logic             w_iq_empty;
    logic [31:0]      w_tag;
    fetch_entry_t     w_iq_in;
    fetch_entry_t     w_iq_head;
    logic             w_req_hs;
    logic             w_keep;
    logic             w_pred;
    logic [31:0]      w_pred_target;
    logic [31:0]      w_pc_next;
    logic [CNT_W-1:0] w_drop_next;

    // Credits come only from registered counts, so instr_ready never reaches the request valid.
    assign imem_req_valid = r_run & ~w_tag_full
                          & (((CNT_W+1)'(w_iq_count) + (CNT_W+1)'(w_live_cnt)) < DEPTH_LIM)
                          & (((CNT_W+1)'(w_live_cnt) + (CNT_W+1)'(r_drop_cnt)) < DEPTH_LIM);
    assign imem_req_addr  = r_pc;
    assign w_req_hs       = imem_req_valid & imem_req_ready;
    assign w_keep         = imem_rsp_valid & ~redirect_valid & (r_drop_cnt == '0) & ~w_tag_empty;

`ifdef STATIC_PREDICT_EN
    assign w_pred        = w_keep & is_branch(imem_rsp_data) & imem_rsp_data[31];
    assign w_pred_target = w_tag + b_imm(imem_rsp_data);
`else
    assign w_pred        = 1'b0;
    assign w_pred_target = 32'h0;
`endif

    assign w_iq_in = '{instr: imem_rsp_data, pc: w_tag, pred: w_pred};

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        w_pc_next   = r_pc;
        w_drop_next = r_drop_cnt;
        if (redirect_valid) begin
            w_pc_next   = redirect_pc & ~32'h3;
            w_drop_next = r_drop_cnt + w_live_cnt + CNT_W'(w_req_hs) - CNT_W'(imem_rsp_valid);
        end else if (w_pred) begin
            // The branch itself is kept; every younger request in flight becomes a drop.
            w_pc_next   = w_pred_target;
            w_drop_next = w_live_cnt - CNT_W'(1) + CNT_W'(w_req_hs);
        end else begin
            if (w_req_hs) w_pc_next = r_pc + 32'd4;
            if (imem_rsp_valid && (r_drop_cnt != '0)) w_drop_next = r_drop_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_run      <= 1'b1;
            r_pc       <= w_pc_next;
            r_drop_cnt <= w_drop_next;
        end
    end

    // Tag queue occupancy is the count of live (to-be-kept) outstanding requests.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_hs),
        .i_data  (r_pc),
        .i_pop   (w_keep),
        .i_flush (redirect_valid | w_pred),
        .o_data  (w_tag),
        .o_count (w_live_cnt),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_keep & ~w_iq_full),
        .i_data  (w_iq_in),
        .i_pop   (instr_ready),
        .i_flush (redirect_valid),
        .o_data  (w_iq_head),
        .o_count (w_iq_count),
        .o_full  (w_iq_full),
        .o_empty (w_iq_empty)
    );

    assign instr_valid = ~w_iq_empty;
    assign instruction = w_iq_empty ? 32'h0 : w_iq_head.instr;
    assign instr_pc    = w_iq_empty ? 32'h0 : w_iq_head.pc;
    assign pred_taken  = ~w_iq_empty & w_iq_head.pred;

endmodule
